// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes and datapath mux selects.
// Pure declarations; no logic, no latency.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_EXEC_I    = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JAL       = 4'd10,
        ST_JALR      = 4'd11,
        ST_LUI       = 4'd12,
        ST_AUIPC     = 4'd13
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Second-operand select, also decoded by the ALU operand mux; 2'b11 is never produced.
    localparam logic [1:0] ALU_SRC_B_REG  = 2'b00;
    localparam logic [1:0] ALU_SRC_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_SRC_B_FOUR = 2'b10;

    localparam logic [1:0] ALU_SRC_A_PC     = 2'b00;
    localparam logic [1:0] ALU_SRC_A_RS1    = 2'b01;
    localparam logic [1:0] ALU_SRC_A_OLD_PC = 2'b10;
    localparam logic [1:0] ALU_SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
    localparam logic [1:0] MEM_TO_REG_MDR = 2'b01;
    localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

    localparam logic [1:0] PC_SOURCE_ALU    = 2'b00;
    localparam logic [1:0] PC_SOURCE_ALUOUT = 2'b01;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_instr;
        logic       instr_done;
    } ctrl_out_t;

    function automatic logic opcode_legal(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: opcode_legal = 1'b1;
            default:                               opcode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_output_decode.sv
// Combinational map of FSM state (plus mem_ready/branch_cond/opcode) to every datapath select and enable.
// Zero latency; memory-handshake enables follow mem_ready in the same cycle.
module control_output_decode
    import ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_cond,
    output ctrl_out_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = ALU_SRC_A_PC;
                ctrl.alu_src_b = ALU_SRC_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SOURCE_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // ALUOut captures old_pc + imm so BRANCH/JAL can use it as the target.
                ctrl.alu_src_a     = ALU_SRC_A_OLD_PC;
                ctrl.alu_src_b     = ALU_SRC_B_IMM;
                ctrl.alu_op        = ALU_OP_ADD;
                ctrl.illegal_instr = ~opcode_legal(opcode);
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = ALU_SRC_A_RS1;
                ctrl.alu_src_b = ALU_SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = MEM_TO_REG_MDR;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = ALU_SRC_A_RS1;
                ctrl.alu_src_b = ALU_SRC_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = ALU_SRC_A_RS1;
                ctrl.alu_src_b = ALU_SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_LUI: begin
                ctrl.alu_src_a = ALU_SRC_A_ZERO;
                ctrl.alu_src_b = ALU_SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_AUIPC: begin
                ctrl.alu_src_a = ALU_SRC_A_OLD_PC;
                ctrl.alu_src_b = ALU_SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = MEM_TO_REG_ALU;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a  = ALU_SRC_A_RS1;
                ctrl.alu_src_b  = ALU_SRC_B_REG;
                ctrl.alu_op     = ALU_OP_BRANCH;
                ctrl.pc_source  = PC_SOURCE_ALUOUT;
                ctrl.pc_write   = branch_cond;
                ctrl.instr_done = 1'b1;
            end
            ST_JAL: begin
                ctrl.pc_source  = PC_SOURCE_ALUOUT;
                ctrl.pc_write   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = MEM_TO_REG_PC;
                ctrl.instr_done = 1'b1;
            end
            ST_JALR: begin
                ctrl.alu_src_a  = ALU_SRC_A_RS1;
                ctrl.alu_src_b  = ALU_SRC_B_IMM;
                ctrl.alu_op     = ALU_OP_ADD;
                ctrl.pc_source  = PC_SOURCE_ALU;
                ctrl.pc_write   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = MEM_TO_REG_PC;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main multicycle RV32I control FSM: state register and next-state logic; outputs decoded from state.
// One state per cycle; FETCH, MEM_READ and MEM_WRITE hold until mem_ready, all outputs forced low during reset.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               branch_cond,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_source,
    output logic               reg_write,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               illegal_instr,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    state_e    r_state;
    state_e    w_next;
    ctrl_out_t w_dec;
    ctrl_out_t w_out;

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH:     w_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: w_next = ST_MEM_ADDR;
                    OPC_OP:              w_next = ST_EXEC_R;
                    OPC_OP_IMM:          w_next = ST_EXEC_I;
                    OPC_BRANCH:          w_next = ST_BRANCH;
                    OPC_JAL:             w_next = ST_JAL;
                    OPC_JALR:            w_next = ST_JALR;
                    OPC_LUI:             w_next = ST_LUI;
                    OPC_AUIPC:           w_next = ST_AUIPC;
                    default:             w_next = ST_FETCH;
                endcase
            end
            // opcode[5] separates store (0100011) from load (0000011).
            ST_MEM_ADDR:  w_next = opcode[5] ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  w_next = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WRITE: w_next = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_AUIPC: w_next = ST_ALU_WB;
            default:      w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FETCH;
        else        r_state <= w_next;
    end

    control_output_decode u_decode (
        .state       (r_state),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .branch_cond (branch_cond),
        .ctrl        (w_dec)
    );

    // Gating with rst_n kills an in-flight memory request the instant reset asserts.
    assign w_out = rst_n ? w_dec : '0;

    assign mem_read      = w_out.mem_read;
    assign mem_write     = w_out.mem_write;
    assign i_or_d        = w_out.i_or_d;
    assign ir_write      = w_out.ir_write;
    assign pc_write      = w_out.pc_write;
    assign pc_source     = w_out.pc_source;
    assign reg_write     = w_out.reg_write;
    assign mem_to_reg    = w_out.mem_to_reg;
    assign alu_src_a     = w_out.alu_src_a;
    assign alu_src_b     = w_out.alu_src_b;
    assign alu_op        = w_out.alu_op;
    assign illegal_instr = w_out.illegal_instr;
    assign instr_done    = w_out.instr_done;
    assign state         = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction cycle traces feed a driver and a scoreboard queue.
// A negedge monitor pops one expected cycle record per clock and compares all outputs.
module tb_multicycle_control_fsm;

    localparam int SW = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       mr, mw, iod, irw, pcw;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] m2r, a, b, op;
        logic       ill, done;
    } out_t;

    typedef struct packed {
        logic [6:0] opc;
        logic       mrdy;
        logic       bc;
        out_t       e;
    } cyc_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic          branch_cond = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
    logic          illegal_instr, instr_done;
    logic [1:0]    pc_source, mem_to_reg, alu_src_a, alu_src_b, alu_op;
    logic [SW-1:0] state;

    multicycle_control_fsm #(.STATE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_cond(branch_cond),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
        .pc_source(pc_source), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal_instr(illegal_instr), .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    out_t act;
    assign act = {state, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
                  reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_instr, instr_done};

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_cyc   = 0;
    cyc_t stim_q[$];
    out_t exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, want);
    endtask

    function automatic logic is_legal(input logic [6:0] opc);
        logic [6:0] tbl [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
        is_legal = 1'b0;
        foreach (tbl[i]) if (tbl[i] == opc) is_legal = 1'b1;
    endfunction

    task automatic put(input logic [6:0] opc, input logic mrdy, input logic bc, input out_t e);
        cyc_t c;
        c.opc = opc; c.mrdy = mrdy; c.bc = bc; c.e = e;
        stim_q.push_back(c);
    endtask

    function automatic out_t blank(input int st);
        out_t o = '0;
        o.st = 4'(st);
        return o;
    endfunction

    // Reference trace of one instruction: fetch stalls, decode, then the class-specific cycles.
    task automatic build(input logic [6:0] opc, input int fst, input int mst, input logic br_bc);
        out_t o;
        logic r;
        for (int i = 0; i <= fst; i++) begin
            o = blank(0); o.mr = 1; o.b = 2'b10;
            o.irw = (i == fst); o.pcw = (i == fst);
            put(7'($urandom), (i == fst), 1'($urandom), o);
        end
        o = blank(1); o.a = 2'b10; o.b = 2'b01; o.ill = !is_legal(opc);
        put(opc, 1'($urandom), 1'($urandom), o);
        r = 1'($urandom);
        case (opc)
            7'h03, 7'h23: begin
                o = blank(2); o.a = 2'b01; o.b = 2'b01;
                put(opc, r, 1'($urandom), o);
                for (int i = 0; i <= mst; i++) begin
                    if (opc == 7'h03) begin
                        o = blank(3); o.mr = 1; o.iod = 1;
                    end else begin
                        o = blank(5); o.mw = 1; o.iod = 1; o.done = (i == mst);
                    end
                    put(opc, (i == mst), 1'($urandom), o);
                end
                if (opc == 7'h03) begin
                    o = blank(4); o.rw = 1; o.m2r = 2'b01; o.done = 1;
                    put(opc, r, 1'($urandom), o);
                end
            end
            7'h33, 7'h13, 7'h37, 7'h17: begin
                case (opc)
                    7'h33:   begin o = blank(6);  o.a = 2'b01; o.b = 2'b00; o.op = 2'b10; end
                    7'h13:   begin o = blank(7);  o.a = 2'b01; o.b = 2'b01; o.op = 2'b10; end
                    7'h37:   begin o = blank(12); o.a = 2'b11; o.b = 2'b01; end
                    default: begin o = blank(13); o.a = 2'b10; o.b = 2'b01; end
                endcase
                put(opc, r, 1'($urandom), o);
                o = blank(8); o.rw = 1; o.done = 1;
                put(opc, 1'($urandom), 1'($urandom), o);
            end
            7'h63: begin
                o = blank(9); o.a = 2'b01; o.op = 2'b01; o.pcs = 2'b01; o.pcw = br_bc; o.done = 1;
                put(opc, r, br_bc, o);
            end
            7'h6f: begin
                o = blank(10); o.pcs = 2'b01; o.pcw = 1; o.rw = 1; o.m2r = 2'b10; o.done = 1;
                put(opc, r, 1'($urandom), o);
            end
            7'h67: begin
                o = blank(11); o.a = 2'b01; o.b = 2'b01; o.pcw = 1; o.rw = 1; o.m2r = 2'b10; o.done = 1;
                put(opc, r, 1'($urandom), o);
            end
            default: ;
        endcase
    endtask

    task automatic run_stim();
        cyc_t c;
        while (stim_q.size() > 0) begin
            c = stim_q.pop_front();
            @(posedge clk);
            #1;
            opcode      = c.opc;
            mem_ready   = c.mrdy;
            branch_cond = c.bc;
            exp_q.push_back(c.e);
        end
    endtask

    always @(negedge clk) begin
        out_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cyc++;
            check($sformatf("cycle%0d_state%0d", n_cyc, e.st), 32'(act), 32'(e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] legal [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
        logic [6:0] opc;
        out_t       o;

        mem_ready = 1'b1;
        #8;
        check("reset_outputs", 32'(act), 32'd0);
        mem_ready = 1'b0;
        #4 rst_n = 1'b1;

        build(7'h33, 0, 0, 1'b0);   // add
        build(7'h03, 0, 3, 1'b0);   // lw with three wait cycles
        build(7'h63, 0, 0, 1'b1);   // beq taken
        build(7'h63, 0, 0, 1'b0);   // beq not taken
        build(7'h7f, 0, 0, 1'b0);   // illegal
        build(7'h6f, 1, 0, 1'b0);   // jal
        run_stim();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 10) < 9) opc = legal[$urandom_range(0, 8)];
            else begin
                opc = 7'($urandom);
                while (is_legal(opc)) opc = 7'($urandom);
            end
            build(opc, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
        end
        run_stim();

        // Store aborted by reset while waiting on memory.
        build(7'h23, 0, 1, 1'b0);
        void'(stim_q.pop_back());
        run_stim();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_all_outputs", 32'(act), 32'd0);
        @(posedge clk);
        @(posedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        o = blank(0); o.mr = 1; o.b = 2'b10;
        check("post_reset_fetch", 32'(act), 32'(o));

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control state machine of the multicycle RV32I datapath. Decodes the latched opcode and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It drives every datapath select and enable, including alu_src_b for the ALU second-operand mux directly downstream. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

Parameters:
STATE_W, 4, width of state register / debug port

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from instruction register
branch_cond  in  1  comparator result for current branch (taken=1)
mem_ready  in  1  memory completes current access this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  address select: 0=PC, 1=ALUOut
ir_write  out  1  load instruction register and old_pc
pc_write  out  1  PC load enable
pc_source  out  2  00=ALU result, 01=ALUOut
reg_write  out  1  register file write enable
mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC (link)
alu_src_a  out  2  00=PC, 01=rs1, 10=old_pc, 11=zero
alu_src_b  out  2  00=rs2, 01=immediate, 10=constant 4; 11 never driven
alu_op  out  2  00=add, 01=branch compare, 10=funct-decoded
illegal_instr  out  1  one-cycle pulse, unsupported opcode
instr_done  out  1  one-cycle pulse, last cycle of an instruction
state  out  STATE_W  current state (debug)

Behaviour:
- Reset: async on rst_n low; state=FETCH; all enables/requests (mem_read, mem_write, ir_write, pc_write, reg_write, illegal_instr, instr_done) forced 0 while rst_n low; selects 00. Reset mid-access aborts the access with no write.
- States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, AUIPC 13. Codes 14/15 go to FETCH next cycle with all outputs 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=10, alu_op=00, pc_source=00. ir_write and pc_write = mem_ready (Mealy). Stay while !mem_ready; else go to DECODE.
- DECODE: alu_src_a=10, alu_src_b=01, alu_op=00 (ALUOut <= branch/JAL target). Next state by opcode: 0000011/0100011 to MEM_ADDR; 0110011 to EXEC_R; 0010011 to EXEC_I; 1100011 to BRANCH; 1101111 to JAL; 1100111 to JALR; 0110111 to LUI; 0010111 to AUIPC. Any other opcode: illegal_instr=1, then FETCH.
- MEM_ADDR: a=01, b=01, op=00. Load goes to MEM_READ; store goes to MEM_WRITE (uses latched opcode[5]).
- MEM_READ: mem_read=1, i_or_d=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=01, instr_done=1, then FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Wait for mem_ready; instr_done=mem_ready; then FETCH.
- EXEC_R: a=01, b=00, op=10. EXEC_I: a=01, b=01, op=10. LUI: a=11, b=01, op=00. AUIPC: a=10, b=01, op=00. All four go to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00, instr_done=1, then FETCH.
- BRANCH: a=01, b=00, op=01, pc_source=01, pc_write=branch_cond, instr_done=1, then FETCH.
- JAL: pc_source=01, pc_write=1, reg_write=1, mem_to_reg=10, instr_done=1, then FETCH.
- JALR: a=01, b=01, op=00, pc_source=00, pc_write=1, reg_write=1, mem_to_reg=10, instr_done=1, then FETCH.
- Any output not listed for a state is 0/00. mem_ready is ignored outside FETCH/MEM_READ/MEM_WRITE.

Decomposition:
- Package ctrl_pkg holds: state encodings; opcode constants; ALU_SRC_B_REG=00, _IMM=01, _FOUR=10 (shared with the ALU operand mux); ALU_SRC_A, MEM_TO_REG, PC_SOURCE and ALU_OP encodings.
- One sub-module, control_output_decode: combinational map of state, mem_ready and branch_cond to outputs. The top holds only the state register and next-state logic.

Test Plan:
- add (opcode 0110011), mem_ready=1 -> states 0,1,6,8,0 over 4 cycles; alu_src_b=10 in FETCH, 01 in DECODE, 00 in EXEC_R; reg_write=1 and instr_done=1 only in ALU_WB.
- lw (0000011), mem_ready low 3 cycles in MEM_READ -> FSM holds in state 3 with mem_read=1 and i_or_d=1 for 4 cycles; MEM_WB then asserts reg_write with mem_to_reg=01.
- beq (1100011) with branch_cond=1, then again with branch_cond=0 -> pc_write 1 vs 0 in BRANCH; pc_source=01 both times; 3 cycles each.
- Opcode 1111111 -> illegal_instr pulses exactly 1 cycle in DECODE; next state FETCH; reg_write/mem_write never asserted.
- sw (0100011) with rst_n low during MEM_WRITE before mem_ready -> state=0 immediately and mem_write=0 asynchronously; after release, FETCH requests mem_read.
- jal (1101111) -> JAL cycle has pc_write=1, reg_write=1, mem_to_reg=10, pc_source=01; total 3 cycles.
